// File: rtl/display_scan_ctrl.sv
// Time-multiplexed N-digit 7-segment scan controller with blanking gap.
// Optional leading-zero blanking: define DISPLAY_SCAN_LZB_EN.
module display_scan_ctrl #(
    parameter int unsigned N_DIG     = 4,
    parameter logic [31:0] SCAN_DIV  = 32'd100000,
    parameter logic [31:0] BLANK_CYC = 32'd16
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               on,
    input  logic               hold,
    input  logic [4*N_DIG-1:0] digits_in,
    input  logic [N_DIG-1:0]   dp_in,
    output logic [N_DIG-1:0]   an_out,
    output logic [6:0]         seg_out,
    output logic               dp_out,
    output logic [2:0]         digit_idx,
    output logic               frame_tick
);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_e;

    localparam logic [31:0] BLANK_LAST = BLANK_CYC - 32'd1;
    localparam logic [31:0] SHOW_LAST  = SCAN_DIV - BLANK_CYC - 32'd1;
    localparam logic [2:0]  LAST_IDX   = 3'(N_DIG - 1);

    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               frame_q, frame_d;

    logic [3:0]         nib;
    logic               dp_sel;
    logic [N_DIG-1:0]   an_sel;
    logic               lz;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Slot digit selection, evaluated on the BLANK -> SHOW edge
    always_comb begin
        nib    = 4'd0;
        dp_sel = 1'b0;
        an_sel = '1;
        for (int i = 0; i < int'(N_DIG); i++) begin
            if (idx_q == 3'(i)) begin
                nib       = digits_in[4*i +: 4];
                dp_sel    = dp_in[i];
                an_sel[i] = 1'b0;
            end
        end
`ifdef DISPLAY_SCAN_LZB_EN
        lz = (idx_q != 3'd0);
        for (int i = 0; i < int'(N_DIG); i++) begin
            if (3'(i) >= idx_q && digits_in[4*i +: 4] != 4'd0)
                lz = 1'b0;
        end
`else
        lz = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        frame_d = 1'b0;
        if (!on) begin
            state_d = S_OFF;
            cnt_d   = 32'd0;
            idx_d   = 3'd0;
            an_d    = '1;
            seg_d   = 7'h7F;
            dp_d    = 1'b1;
        end else if (!hold) begin
            unique case (state_q)
                S_OFF: begin
                    state_d = S_BLANK;
                    cnt_d   = 32'd0;
                    idx_d   = 3'd0;
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                        cnt_d   = 32'd0;
                        an_d    = an_sel;
                        seg_d   = lz ? 7'h7F : decode(nib);
                        dp_d    = ~dp_sel;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = 32'd0;
                        idx_d   = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
                        frame_d = (idx_q == LAST_IDX);
                        an_d    = '1;
                        seg_d   = 7'h7F;
                        dp_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= S_OFF;
            cnt_q   <= 32'd0;
            idx_q   <= 3'd0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign digit_idx  = idx_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a time-position model.
module tb_display_scan_ctrl;

    localparam int N     = 4;
    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = N * SD;

    logic        clk = 1'b0;
    logic        reset, on, hold;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [2:0]  digit_idx;
    logic        frame_tick;

    display_scan_ctrl #(
        .N_DIG(N), .SCAN_DIV(32'd8), .BLANK_CYC(32'd2)
    ) dut (
        .clock_in(clk), .reset(reset), .on(on), .hold(hold),
        .digits_in(digits), .dp_in(dp),
        .an_out(an_out), .seg_out(seg_out), .dp_out(dp_out),
        .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: t = counted cycles since scanning started
    bit         started = 0;
    int         t = 0;
    logic [3:0] snap = 0;
    logic       snap_dp = 0;
    bit         snap_lz = 0;
    bit         frame_exp = 0;
    int         cyc = 0;

    task automatic model_edge();
        int k;
        frame_exp = 0;
        if (reset || !on) begin
            started = 0;
        end else if (hold) begin
        end else if (!started) begin
            started = 1;
            t = 0;
        end else begin
            t++;
            frame_exp = (t % FRAME == 0);
            if (t % SD == BL) begin
                k       = (t / SD) % N;
                snap    = digits[4*k +: 4];
                snap_dp = dp[k];
                snap_lz = 0;
`ifdef DISPLAY_SCAN_LZB_EN
                snap_lz = (k > 0);
                for (int j = k; j < N; j++)
                    if (digits[4*j +: 4] != 4'd0) snap_lz = 0;
`endif
            end
        end
    endtask

    task automatic check_outputs();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         e_idx;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_idx = 0;
        if (started) begin
            e_idx = (t / SD) % N;
            if (t % SD >= BL) begin
                e_an[e_idx] = 1'b0;
                e_seg = snap_lz ? 7'h7F : dec[snap];
                e_dp  = ~snap_dp;
            end
        end
        check("an_out", an_out, e_an);
        check("seg_out", seg_out, e_seg);
        check("dp_out", dp_out, e_dp);
        check("digit_idx", digit_idx, e_idx);
        check("frame_tick", frame_tick, frame_exp);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int last_tick;
        reset  = 1'b1;
        on     = 1'b0;
        hold   = 1'b0;
        digits = 16'h1234;
        dp     = 4'h0;
        @(negedge clk);
        step();
        step();

        // Free-run: frame_tick period must be one full frame
        reset     = 1'b0;
        on        = 1'b1;
        last_tick = -1;
        for (int i = 0; i < 110; i++) begin
            step();
            if (frame_tick) begin
                if (last_tick >= 0)
                    check("frame_period", cyc - last_tick, FRAME);
                last_tick = cyc;
            end
        end

        // Randomized on/hold/data/reset traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                digits = 16'($urandom);
                if ($urandom_range(0, 1) == 1)
                    digits = digits & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            end
            if ($urandom_range(0, 3) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            if (on) begin
                if ($urandom_range(0, 59) == 0) on = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                on = 1'b1;
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
        end

        // Leading zeros
        reset  = 1'b0;
        hold   = 1'b0;
        on     = 1'b0;
        digits = 16'h0070;
        dp     = 4'h0;
        step();
        on = 1'b1;
        for (int i = 0; i < 40; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
